sha256_host_ctrl: RTL and testbench

Host-side command master for the sha256 core's command/text register interface. Accepts pre-padded 512-bit message blocks as a 32-bit word stream, buffers each block, and bursts it into the core with a write command. It then tracks the core's busy status and, after the final block, issues a read command. The captured 256-bit digest is returned as an 8-word stream. Sits between a DMA/bus front end and one sha256 instance.

---
 rtl/sha256_host_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sha256_host_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_host_ctrl.sv
`default_nettype none
// ============================================================================
// sha256_host_ctrl : buffers 512-bit blocks, bursts them into a sha256 core
// and streams the 256-bit digest back out.          Revision: 1.0
// ============================================================================
module sha256_host_ctrl #(
  parameter int BUSY_RISE_MAX = 8,
  parameter int BUSY_FALL_MAX = 128,
  parameter int RD_LAT        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] blk_data_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  input  logic        blk_first_i,
  input  logic        blk_last_i,
  output logic [31:0] dig_data_o,
  output logic        dig_valid_o,
  input  logic        dig_ready_i,
  output logic        dig_last_o,
  output logic [31:0] core_text_o,
  input  logic [31:0] core_text_i,
  output logic [2:0]  core_cmd_o,
  output logic        core_cmd_w_o,
  input  logic [3:0]  core_cmd_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_CMD       = 4'd2,
    S_PUSH      = 4'd3,
    S_WAIT_BUSY = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_RD_CMD    = 4'd6,
    S_RD_CAP    = 4'd7,
    S_OUT       = 4'd8,
    S_ERR       = 4'd9
  } state_e;

  localparam logic [7:0] c_rise_max = 8'(BUSY_RISE_MAX);
  localparam logic [7:0] c_fall_max = 8'(BUSY_FALL_MAX);
  localparam logic [7:0] c_rd_lat   = 8'(RD_LAT);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic        busy_seen_q, busy_seen_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic [2:0]  out_idx_q, out_idx_d;
  logic        blk_ready_q, blk_ready_d;

  logic [31:0] blk_buf_q [16];
  logic [31:0] dig_buf_q [8];

  logic        blk_we;
  logic        dig_we;
  logic        blk_fire;
  logic        dig_fire;
  logic        core_busy;
  logic        unused_status;
  logic [7:0]  rd_off;
  logic [7:0]  timer_inc;
  logic [7:0]  busy_inc;

  assign core_busy     = core_cmd_i[3];
  assign unused_status = ^core_cmd_i[2:0];
  assign blk_fire      = blk_valid_i & blk_ready_q;
  assign dig_fire      = dig_valid_o & dig_ready_i;
  assign rd_off        = rd_cnt_q - c_rd_lat;
  assign timer_inc     = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
  assign busy_inc      = (busy_cnt_q == 8'hFF) ? busy_cnt_q : busy_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    first_d     = first_q;
    last_d      = last_q;
    timer_d     = timer_q;
    busy_cnt_d  = busy_cnt_q;
    busy_seen_d = busy_seen_q;
    rd_cnt_d    = 8'd0;
    out_idx_d   = out_idx_q;
    blk_we      = 1'b0;
    dig_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (blk_fire) begin
          blk_we  = 1'b1;
          first_d = blk_first_i;
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (blk_fire) begin
          blk_we = 1'b1;
          idx_d  = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            last_d      = blk_last_i;
            timer_d     = 8'd0;
            busy_cnt_d  = 8'd0;
            busy_seen_d = 1'b0;
            state_d     = S_CMD;
          end
        end
      end
      S_CMD, S_PUSH, S_WAIT_BUSY, S_WAIT_DONE: begin
        // Busy may rise (and even fall) while the burst is still in flight,
        // so the rise/fall tracking runs from the command cycle onward.
        timer_d     = timer_inc;
        busy_seen_d = busy_seen_q | core_busy;
        if (core_busy) begin
          busy_cnt_d = busy_inc;
        end
        if (state_q == S_CMD || state_q == S_PUSH) begin
          idx_d = idx_q + 4'd1;
          if (state_q == S_PUSH && idx_q == 4'd15) begin
            state_d = S_WAIT_BUSY;
          end else if (state_q == S_CMD) begin
            state_d = S_PUSH;
          end
        end else if (state_q == S_WAIT_BUSY) begin
          if (busy_seen_d) begin
            state_d = S_WAIT_DONE;
          end
        end else if (!core_busy) begin
          state_d = last_q ? S_RD_CMD : S_IDLE;
        end
        if ((!busy_seen_d && (timer_inc > c_rise_max)) ||
            (core_busy && (busy_inc > c_fall_max))) begin
          state_d = S_ERR;
        end
      end
      S_RD_CMD, S_RD_CAP: begin
        rd_cnt_d = rd_cnt_q + 8'd1;
        dig_we   = (rd_cnt_q >= c_rd_lat);
        if (state_q == S_RD_CMD) begin
          state_d = S_RD_CAP;
        end else if (dig_we && rd_off == 8'd7) begin
          out_idx_d = 3'd0;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (dig_fire) begin
          out_idx_d = out_idx_q + 3'd1;
          if (out_idx_q == 3'd7) begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    blk_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      timer_q     <= 8'd0;
      busy_cnt_q  <= 8'd0;
      busy_seen_q <= 1'b0;
      rd_cnt_q    <= 8'd0;
      out_idx_q   <= 3'd0;
      blk_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      busy_cnt_q  <= busy_cnt_d;
      busy_seen_q <= busy_seen_d;
      rd_cnt_q    <= rd_cnt_d;
      out_idx_q   <= out_idx_d;
      blk_ready_q <= blk_ready_d;
    end
  end

  // Data buffers carry no reset; they are only read in states that follow a fill.
  always_ff @(posedge clk_i) begin
    if (blk_we) begin
      blk_buf_q[idx_q] <= blk_data_i;
    end
    if (dig_we) begin
      dig_buf_q[rd_off[2:0]] <= core_text_i;
    end
  end

  assign blk_ready_o  = blk_ready_q;
  assign core_cmd_w_o = (state_q == S_CMD) || (state_q == S_RD_CMD);
  assign core_cmd_o   = (state_q == S_CMD)    ? {~first_q, 2'b10} :
                        (state_q == S_RD_CMD) ? 3'b001 : 3'b000;
  assign core_text_o  = (state_q == S_CMD || state_q == S_PUSH) ? blk_buf_q[idx_q] : 32'd0;
  assign dig_valid_o  = (state_q == S_OUT);
  assign dig_data_o   = (state_q == S_OUT) ? dig_buf_q[out_idx_q] : 32'd0;
  assign dig_last_o   = (state_q == S_OUT) && (out_idx_q == 3'd7);
  assign busy_o       = (state_q != S_IDLE);
  assign err_o        = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_sha256_host_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sha256_host_ctrl : directed bench with a behavioural sha256 core model.
// Revision: 1.0
// ============================================================================
module tb_sha256_host_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] blk_data = 32'd0;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic        blk_first = 1'b0;
  logic        blk_last = 1'b0;
  logic [31:0] dig_data;
  logic        dig_valid;
  logic        dig_ready = 1'b0;
  logic        dig_last;
  logic [31:0] core_text_o;
  logic [31:0] core_text_i;
  logic [2:0]  core_cmd_o;
  logic        core_cmd_w;
  logic [3:0]  core_cmd_i;
  logic        busy;
  logic        err;

  sha256_host_ctrl #(.BUSY_RISE_MAX(8), .BUSY_FALL_MAX(128), .RD_LAT(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .blk_data_i(blk_data), .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
    .blk_first_i(blk_first), .blk_last_i(blk_last),
    .dig_data_o(dig_data), .dig_valid_o(dig_valid), .dig_ready_i(dig_ready),
    .dig_last_o(dig_last),
    .core_text_o(core_text_o), .core_text_i(core_text_i),
    .core_cmd_o(core_cmd_o), .core_cmd_w_o(core_cmd_w), .core_cmd_i(core_cmd_i),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural sha256 core ----------------
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror32(w[i-15], 7) ^ ror32(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror32(w[i-2], 17) ^ ror32(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  int           mode = 0;   // 0 normal, 1 busy never rises, 2 busy stuck high
  int           mcyc = 0;
  int           wcnt = 0;
  int           rcnt = 0;
  int           rd_cmds = 0;
  logic [511:0] m_blk;
  logic [255:0] m_h;
  logic         m_busy;

  assign m_busy     = (mode == 0) ? (mcyc >= 2 && mcyc < 40) : (mode == 2) ? (mcyc >= 2) : 1'b0;
  assign core_cmd_i = {m_busy, 3'b000};

  always @(posedge clk) begin
    if (rst) begin
      mcyc        <= 0;
      wcnt        <= 0;
      rcnt        <= 0;
      core_text_i <= 32'hDEADBEEF;
    end else begin
      if (mcyc != 0) mcyc <= mcyc + 1;
      if (core_cmd_w && core_cmd_o[1]) begin
        mcyc            <= 1;
        wcnt            <= 1;
        m_blk[511 -: 32] <= core_text_o;
        if (!core_cmd_o[2]) m_h <= IV;
      end else if (wcnt >= 1 && wcnt <= 15) begin
        m_blk[511-32*wcnt -: 32] <= core_text_o;
        wcnt <= wcnt + 1;
      end else if (wcnt == 16) begin
        m_h  <= sha_compress(m_h, m_blk);
        wcnt <= 0;
      end
      if (core_cmd_w && core_cmd_o == 3'b001) begin
        rcnt    <= 1;
        rd_cmds <= rd_cmds + 1;
      end else if (rcnt >= 1 && rcnt <= 8) begin
        core_text_i <= m_h[255-32*(rcnt-1) -: 32];
        rcnt        <= rcnt + 1;
      end else begin
        core_text_i <= 32'hDEADBEEF;
        rcnt        <= 0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] blk, input logic first, input logic last, input bit gap);
    logic all_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      blk_valid = 1'b1;
      blk_data  = blk[511-32*i -: 32];
      blk_first = (i == 0)  ? first : 1'b0;
      blk_last  = (i == 15) ? last  : 1'b0;
      for (int t = 0; t < 300 && !blk_ready; t++) tick();
      all_ready = all_ready & blk_ready;
      tick();
      blk_valid = 1'b0;
      if (gap && i < 15) tick();
    end
    blk_first = 1'b0;
    blk_last  = 1'b0;
    check("blk_accept", 32'(all_ready), 32'd1);
  endtask

  task automatic check_burst(input logic [511:0] blk, input logic [2:0] cmd_exp);
    int w_pulses = 0;
    check("wr_cmd_w", 32'(core_cmd_w), 32'd1);
    check("wr_cmd", 32'(core_cmd_o), 32'(cmd_exp));
    check("text_w0", core_text_o, blk[511 -: 32]);
    for (int k = 1; k < 16; k++) begin
      tick();
      if (core_cmd_w) w_pulses++;
      check("text_wk", core_text_o, blk[511-32*k -: 32]);
    end
    check("push_cmd_w", 32'(w_pulses), 32'd0);
  endtask

  task automatic wait_rd_cmd();
    for (int t = 0; t < 300 && !core_cmd_w; t++) tick();
    check("rd_cmd_w", 32'(core_cmd_w), 32'd1);
    check("rd_cmd", 32'(core_cmd_o), 32'd1);
  endtask

  task automatic get_digest(input logic [255:0] exp, input bit hold);
    dig_ready = 1'b1;
    for (int t = 0; t < 300 && !dig_valid; t++) tick();
    check("dig_valid", 32'(dig_valid), 32'd1);
    for (int j = 0; j < 8; j++) begin
      if (hold && j == 3) begin
        dig_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("dig_hold", dig_data, exp[255-32*j -: 32]);
        end
        dig_ready = 1'b1;
      end
      check("dig_word", dig_data, exp[255-32*j -: 32]);
      check("dig_last", 32'(dig_last), 32'(j == 7));
      tick();
    end
    check("dig_end_valid", 32'(dig_valid), 32'd0);
    check("idle_ready", 32'(blk_ready), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_blk_ready", 32'(blk_ready), 32'd0);
    check("rst_dig_valid", 32'(dig_valid), 32'd0);
    check("rst_dig_last", 32'(dig_last), 32'd0);
    check("rst_cmd_w", 32'(core_cmd_w), 32'd0);
    check("rst_cmd", 32'(core_cmd_o), 32'd0);
    check("rst_text", core_text_o, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [511:0] abc_blk;
    logic [511:0] b1;
    logic [511:0] b2;
    logic [255:0] abc_dig;
    logic [255:0] two_dig;
    int           rd_base;

    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    b1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    b2 = {480'h0, 32'h000001c0};
    abc_dig = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    two_dig = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check_reset_outputs();
    tick();
    check("idle_ready_after_rst", 32'(blk_ready), 32'd1);

    // single block "abc"
    rd_base = rd_cmds;
    send_block(abc_blk, 1'b1, 1'b1, 1'b0);
    check_burst(abc_blk, 3'b010);
    wait_rd_cmd();
    get_digest(abc_dig, 1'b0);
    check("abc_rd_count", 32'(rd_cmds - rd_base), 32'd1);

    // two-block message
    rd_base = rd_cmds;
    send_block(b1, 1'b1, 1'b0, 1'b0);
    check_burst(b1, 3'b010);
    send_block(b2, 1'b0, 1'b1, 1'b0);
    check_burst(b2, 3'b110);
    wait_rd_cmd();
    get_digest(two_dig, 1'b0);
    check("two_rd_count", 32'(rd_cmds - rd_base), 32'd1);

    // toggling valid plus stalled digest sink
    send_block(abc_blk, 1'b1, 1'b1, 1'b1);
    check_burst(abc_blk, 3'b010);
    wait_rd_cmd();
    get_digest(abc_dig, 1'b1);

    // busy never rises
    mode = 1;
    send_block(abc_blk, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("rise_err_c8", 32'(err), 32'd0);
    tick();
    check("rise_err_c9", 32'(err), 32'd1);
    check("rise_err_ready", 32'(blk_ready), 32'd0);
    check("rise_err_cmd_w", 32'(core_cmd_w), 32'd0);
    blk_valid = 1'b1;
    tick(); tick(); tick();
    check("rise_err_sticky", 32'(err), 32'd1);
    check("rise_err_ready_hold", 32'(blk_ready), 32'd0);
    check("rise_err_dig_valid", 32'(dig_valid), 32'd0);
    blk_valid = 1'b0;
    do_reset();
    check("err_clear", 32'(err), 32'd0);

    // busy stuck high
    mode = 2;
    tick();
    send_block(abc_blk, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 130; i++) tick();
    check("fall_err_c130", 32'(err), 32'd0);
    tick();
    check("fall_err_c131", 32'(err), 32'd1);
    check("fall_err_ready", 32'(blk_ready), 32'd0);
    mode = 0;
    do_reset();

    // reset in the middle of the burst, then a fresh block
    tick();
    send_block(b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("push_k7_text", core_text_o, b1[511-32*7 -: 32]);
    do_reset();
    check_reset_outputs();
    rd_base = rd_cmds;
    send_block(abc_blk, 1'b1, 1'b1, 1'b0);
    check_burst(abc_blk, 3'b010);
    wait_rd_cmd();
    get_digest(abc_dig, 1'b0);
    check("post_rst_rd_count", 32'(rd_cmds - rd_base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
